// File: rtl/ldpc_cn_pkg.sv
// Shared types for the min-sum check-node datapath: default widths, the
// emitter FSM encoding and the compressed check-node state.
package ldpc_cn_pkg;

  localparam int unsigned CN_MAG_W   = 5;
  localparam int unsigned CN_IDX_W   = 6;
  localparam int unsigned CN_DEG_MAX = 1 << CN_IDX_W;

  typedef enum logic {
    IDLE,
    EMIT
  } cn_fsm_t;

  // signs is sized for the largest legal degree; unused upper bits stay zero
  typedef struct packed {
    logic [CN_MAG_W-1:0]   min1;
    logic [CN_MAG_W-1:0]   min2;
    logic [CN_IDX_W-1:0]   min_idx;
    logic                  sign_prod;
    logic [CN_DEG_MAX-1:0] signs;
  } cn_state_t;

endpackage

// File: rtl/cn_message_emitter_edge_index_counter.sv
// Edge index counter for the check-node emitter: counts 0..DEG-1 on enable,
// wraps to 0, and can be synchronously cleared when a new frame is loaded.
module edge_index_counter #(
  parameter int unsigned DEG   = 32,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == IDX_W'(DEG - 1)) ? '0 : count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/cn_message_emitter.sv
// Serial check-node output stage: expands one compressed min-sum state into
// DEG offset-corrected check-to-variable messages, one edge per cycle.
module cn_message_emitter
  import ldpc_cn_pkg::*;
#(
  parameter int unsigned DEG    = 32,
  parameter int unsigned MAG_W  = CN_MAG_W,
  parameter int unsigned IDX_W  = CN_IDX_W,
  parameter int unsigned OFFSET = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_min1,
  input  logic [MAG_W-1:0] in_min2,
  input  logic [IDX_W-1:0] in_min_idx,
  input  logic             in_sign_prod,
  input  logic [DEG-1:0]   in_signs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_sign,
  output logic [MAG_W-1:0] out_mag,
  output logic             out_last
);

  cn_fsm_t    state;
  cn_state_t  active;
  cn_state_t  pending;
  cn_state_t  load_st;
  logic       pending_full;
  logic [IDX_W-1:0] count;
  logic       fire;
  logic       at_last;
  logic       last_fire;
  logic       load;
  logic [CN_MAG_W-1:0] base;
  logic [CN_MAG_W-1:0] mag_c;

  always_comb begin
    load_st           = '0;
    load_st.min1      = CN_MAG_W'(in_min1);
    load_st.min2      = CN_MAG_W'(in_min2);
    load_st.min_idx   = CN_IDX_W'(in_min_idx);
    load_st.sign_prod = in_sign_prod;
    load_st.signs     = CN_DEG_MAX'(in_signs);
  end

  assign in_ready  = !pending_full;
  assign out_valid = (state == EMIT);
  assign fire      = out_valid && out_ready;
  assign at_last   = (count == IDX_W'(DEG - 1));
  assign last_fire = fire && at_last;
  assign load      = in_valid && in_ready;

  edge_index_counter #(
    .DEG   (DEG),
    .IDX_W (IDX_W)
  ) u_edge_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (fire),
    .clr   (load && (state == IDLE)),
    .count (count)
  );

  // On the last beat a waiting pending entry takes priority; in_ready is low
  // then, so a simultaneous load cannot occur in that case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            active <= load_st;
            state  <= EMIT;
          end
        end
        EMIT: begin
          if (last_fire) begin
            if (pending_full) begin
              active       <= pending;
              pending_full <= 1'b0;
            end else if (load) begin
              active <= load_st;
            end else begin
              state <= IDLE;
            end
          end else if (load) begin
            pending      <= load_st;
            pending_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An out-of-range min_idx never equals the counter, so every edge gets min1.
  assign base  = (CN_IDX_W'(count) == active.min_idx) ? active.min2 : active.min1;
  assign mag_c = (base > CN_MAG_W'(OFFSET)) ? base - CN_MAG_W'(OFFSET) : '0;

  assign out_idx  = count;
  assign out_sign = out_valid && (active.sign_prod ^ active.signs[count]);
  assign out_mag  = out_valid ? MAG_W'(mag_c) : '0;
  assign out_last = out_valid && at_last;

endmodule

// File: tb/tb_cn_message_emitter.sv
// Directed bench for cn_message_emitter: a DEG=4 instance for framing,
// saturation, back-to-back, stall and reset cases, and a DEG=32 instance.
module tb_cn_message_emitter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DEG=4 instance
  logic       a_in_valid, a_in_ready, a_sp, a_out_valid, a_out_ready;
  logic       a_out_sign, a_out_last;
  logic [4:0] a_min1, a_min2, a_out_mag;
  logic [5:0] a_min_idx, a_out_idx;
  logic [3:0] a_signs;

  cn_message_emitter #(.DEG(4), .MAG_W(5), .IDX_W(6), .OFFSET(1)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_min1(a_min1), .in_min2(a_min2), .in_min_idx(a_min_idx),
    .in_sign_prod(a_sp), .in_signs(a_signs),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_idx(a_out_idx), .out_sign(a_out_sign), .out_mag(a_out_mag),
    .out_last(a_out_last)
  );

  // DEG=32 instance
  logic        b_in_valid, b_in_ready, b_sp, b_out_valid, b_out_ready;
  logic        b_out_sign, b_out_last;
  logic [4:0]  b_min1, b_min2, b_out_mag;
  logic [5:0]  b_min_idx, b_out_idx;
  logic [31:0] b_signs;

  cn_message_emitter #(.DEG(32), .MAG_W(5), .IDX_W(6), .OFFSET(1)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_min1(b_min1), .in_min2(b_min2), .in_min_idx(b_min_idx),
    .in_sign_prod(b_sp), .in_signs(b_signs),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_idx(b_out_idx), .out_sign(b_out_sign), .out_mag(b_out_mag),
    .out_last(b_out_last)
  );

  task automatic a_load(input logic [4:0] m1, input logic [4:0] m2, input logic [5:0] mi,
                        input logic sp, input logic [3:0] sg);
    int unsigned waited;
    waited = 0;
    @(negedge clk);
    a_in_valid = 1'b1;
    a_min1 = m1; a_min2 = m2; a_min_idx = mi; a_sp = sp; a_signs = sg;
    while (!a_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("load_timeout", 32'(a_in_ready), 32'd1);
    else @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask

  // Expect one DEG=4 frame; sg[k] is the sign and mg[5k+:5] the magnitude of edge k.
  task automatic a_expect(input string tag, input logic [3:0] sg, input logic [19:0] mg,
                          input bit stall);
    int unsigned k;
    int unsigned cyc;
    logic rdy;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rdy = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
      a_out_ready = rdy;
      check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
      check({tag, "_idx"},   32'(a_out_idx), k);
      check({tag, "_sign"},  32'(a_out_sign), 32'(sg[k]));
      check({tag, "_mag"},   32'(a_out_mag), 32'(mg[5*k +: 5]));
      check({tag, "_last"},  32'(a_out_last), 32'(k == 3));
      if (rdy) k++;
    end
    if (k < 4) check({tag, "_timeout"}, k, 32'd4);
    a_out_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] sgv;
    a_in_valid = 0; a_out_ready = 1; a_min1 = 0; a_min2 = 0; a_min_idx = 0; a_sp = 0; a_signs = 0;
    b_in_valid = 0; b_out_ready = 1; b_min1 = 0; b_min2 = 0; b_min_idx = 0; b_sp = 0; b_signs = 0;

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_ready", 32'(a_in_ready), 32'd1);
    check("rst_idx",   32'(a_out_idx), 32'd0);
    check("rst_sign",  32'(a_out_sign), 32'd0);
    check("rst_mag",   32'(a_out_mag), 32'd0);
    check("rst_last",  32'(a_out_last), 32'd0);
    check("rst_b_valid", 32'(b_out_valid), 32'd0);
    reset = 1'b0;

    // 1: basic frame
    a_load(5'd3, 5'd7, 6'd2, 1'b1, 4'b0101);
    a_expect("s1", 4'b1010, {5'd2, 5'd6, 5'd2, 5'd2}, 1'b0);
    @(negedge clk);
    check("s1_drop_valid", 32'(a_out_valid), 32'd0);
    check("s1_drop_last",  32'(a_out_last), 32'd0);

    // 2: saturation at zero
    a_load(5'd0, 5'd1, 6'd0, 1'b0, 4'b0011);
    a_expect("s2", 4'b0011, 20'd0, 1'b0);

    // 3: second frame parked in pending while the first emits
    a_load(5'd3, 5'd7, 6'd2, 1'b1, 4'b0101);
    fork
      begin
        a_load(5'd4, 5'd5, 6'd3, 1'b0, 4'b1001);
        @(negedge clk);
        check("s3_ready_low", 32'(a_in_ready), 32'd0);
      end
      begin
        a_expect("s3a", 4'b1010, {5'd2, 5'd6, 5'd2, 5'd2}, 1'b0);
        a_expect("s3b", 4'b1001, {5'd4, 5'd3, 5'd3, 5'd3}, 1'b0);
      end
    join
    @(negedge clk);
    check("s3_end_valid", 32'(a_out_valid), 32'd0);
    check("s3_end_ready", 32'(a_in_ready), 32'd1);

    // 3b: load arriving on the last beat bypasses straight into active
    a_load(5'd4, 5'd5, 6'd3, 1'b0, 4'b1001);
    fork
      begin
        repeat (3) @(negedge clk);
        a_load(5'd1, 5'd2, 6'd1, 1'b1, 4'b0000);
      end
      begin
        a_expect("s3c", 4'b1001, {5'd4, 5'd3, 5'd3, 5'd3}, 1'b0);
        a_expect("s3d", 4'b1111, {5'd0, 5'd0, 5'd1, 5'd0}, 1'b0);
      end
    join
    @(negedge clk);
    check("s3d_end_valid", 32'(a_out_valid), 32'd0);

    // 4: random backpressure
    a_load(5'd3, 5'd7, 6'd2, 1'b1, 4'b0101);
    a_expect("s4", 4'b1010, {5'd2, 5'd6, 5'd2, 5'd2}, 1'b1);
    @(negedge clk);
    check("s4_drop_valid", 32'(a_out_valid), 32'd0);

    // 5: reset at beat 2 with pending full
    a_load(5'd3, 5'd7, 6'd2, 1'b1, 4'b0101);
    a_load(5'd4, 5'd5, 6'd3, 1'b0, 4'b1001);
    @(negedge clk);
    check("s5_beat1", 32'(a_out_idx), 32'd1);
    @(negedge clk);
    check("s5_beat2", 32'(a_out_idx), 32'd2);
    check("s5_pend_full", 32'(a_in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("s5_rst_valid", 32'(a_out_valid), 32'd0);
    check("s5_rst_ready", 32'(a_in_ready), 32'd1);
    check("s5_rst_idx",   32'(a_out_idx), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("s5_post_valid", 32'(a_out_valid), 32'd0);
    check("s5_post_ready", 32'(a_in_ready), 32'd1);
    a_load(5'd3, 5'd7, 6'd2, 1'b1, 4'b0101);
    a_expect("s5", 4'b1010, {5'd2, 5'd6, 5'd2, 5'd2}, 1'b0);

    // 6: DEG=32 with out-of-range min_idx: every edge gets min1 - OFFSET
    sgv = 32'hA5A5_0F0F;
    @(negedge clk);
    check("s6_ready", 32'(b_in_ready), 32'd1);
    b_min1 = 5'd9; b_min2 = 5'd3; b_min_idx = 6'd63; b_sp = 1'b0; b_signs = sgv;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    for (int unsigned k = 0; k < 32; k++) begin
      @(negedge clk);
      check("s6_valid", 32'(b_out_valid), 32'd1);
      check("s6_idx",   32'(b_out_idx), k);
      check("s6_sign",  32'(b_out_sign), 32'(sgv[k]));
      check("s6_mag",   32'(b_out_mag), 32'd8);
      check("s6_last",  32'(b_out_last), 32'(k == 31));
    end
    @(negedge clk);
    check("s6_drop_valid", 32'(b_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
